// File: rtl/spi_xfer_sequencer_pkg.sv
// Shared definitions for the SPI transfer sequencer: character length width and FSM state encodings.
package spi_xfer_sequencer_pkg;

   localparam int SPI_CHAR_LEN_BITS = 7;
   localparam int SPI_MAX_CHAR      = 128;

   typedef enum logic [2:0] {
      SEQ_IDLE = 3'd0,
      SEQ_LOAD = 3'd1,
      SEQ_GO   = 3'd2,
      SEQ_BUSY = 3'd3,
      SEQ_DONE = 3'd4
   } seq_state_t;

endpackage

// File: rtl/spi_xfer_sequencer_if.sv
// Requester and shift-register link of the SPI transfer sequencer.
// The slave modport is the sequencer's view; master is the environment driving it.
interface spi_xfer_sequencer_if
   import spi_xfer_sequencer_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int SS_NB   = 8
);
   logic [NUM_REQ-1:0]                   req;
   logic [NUM_REQ*SPI_CHAR_LEN_BITS-1:0] req_len;
   logic [NUM_REQ*32-1:0]                req_data;
   logic [NUM_REQ*SS_NB-1:0]             req_ss;
   logic [NUM_REQ-1:0]                   ack;
   logic [31:0]                          rdata;
   logic                                 busy;
   logic [31:0]                          sr_p_in;
   logic [3:0]                           sr_latch;
   logic [3:0]                           sr_byte_sel;
   logic [SPI_CHAR_LEN_BITS-1:0]         sr_len;
   logic                                 sr_go;
   logic                                 sr_tip;
   logic [31:0]                          sr_p_out;
   logic [SS_NB-1:0]                     ss_pad_o;

   modport slave (
      input  req, req_len, req_data, req_ss, sr_tip, sr_p_out,
      output ack, rdata, busy, sr_p_in, sr_latch, sr_byte_sel, sr_len, sr_go, ss_pad_o
   );

   modport master (
      output req, req_len, req_data, req_ss, sr_tip, sr_p_out,
      input  ack, rdata, busy, sr_p_in, sr_latch, sr_byte_sel, sr_len, sr_go, ss_pad_o
   );

endinterface

// File: rtl/spi_xfer_sequencer_arbiter.sv
// Combinational round-robin arbiter: first asserted request searching upward from rr_ptr, wrapping.
module spi_rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   rr_ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grant_idx
);

   int   lo_sel;
   int   hi_sel;
   int   sel;
   logic hi_found;

   // Lowest request at or above the pointer wins; otherwise wrap to the lowest request overall.
   always_comb begin
      lo_sel   = 0;
      hi_sel   = 0;
      hi_found = 1'b0;
      grant    = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req[i]) begin
            lo_sel = i;
         end
         if (req[i] && (i >= int'(rr_ptr))) begin
            hi_sel   = i;
            hi_found = 1'b1;
         end
      end
      sel       = hi_found ? hi_sel : lo_sel;
      grant_idx = IDX_W'(sel);
      for (int i = 0; i < NUM_REQ; i++) begin
         grant[i] = req[i] && (i == sel);
      end
   end

endmodule

// File: rtl/spi_xfer_sequencer.sv
// Shares one SPI shift register among NUM_REQ requesters: arbitrates, loads, starts and
// tracks each transfer, returns RX data with a one-cycle ack and spaces slave selects apart.
module spi_xfer_sequencer
   import spi_xfer_sequencer_pkg::*;
#(
   parameter int NUM_REQ    = 2,
   parameter int SS_NB      = 8,
   parameter int GAP_CYCLES = 4
) (
   input logic                   wb_clk_in,
   input logic                   wb_rst,
   spi_xfer_sequencer_if.slave   bus
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int GAP_W = $clog2(GAP_CYCLES + 1);
   localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(GAP_CYCLES);
   localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_REQ - 1);

   seq_state_t                   state;
   logic [IDX_W-1:0]             rr_ptr;
   logic [IDX_W-1:0]             idx_q;
   logic [NUM_REQ-1:0]           gnt_q;
   logic [GAP_W-1:0]             gap_cnt;
   logic [NUM_REQ-1:0]           grant;
   logic [IDX_W-1:0]             grant_idx;
   logic [SPI_CHAR_LEN_BITS-1:0] sel_len;
   logic [31:0]                  sel_data;
   logic [SS_NB-1:0]             sel_mask;

   spi_rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_arb (
      .req       (bus.req),
      .rr_ptr    (rr_ptr),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   // Pick out the winning requester's length, data and slave mask.
   always_comb begin
      sel_len  = '0;
      sel_data = '0;
      sel_mask = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            sel_len  = bus.req_len[i*SPI_CHAR_LEN_BITS +: SPI_CHAR_LEN_BITS];
            sel_data = bus.req_data[i*32 +: 32];
            sel_mask = bus.req_ss[i*SS_NB +: SS_NB];
         end
      end
   end

   // The gap counter also advances in DONE, since the selects are already released there.
   always_ff @(posedge wb_clk_in or posedge wb_rst) begin
      if (wb_rst) begin
         state           <= SEQ_IDLE;
         rr_ptr          <= '0;
         idx_q           <= '0;
         gnt_q           <= '0;
         gap_cnt         <= GAP_MAX;
         bus.ack         <= '0;
         bus.rdata       <= '0;
         bus.busy        <= 1'b0;
         bus.sr_p_in     <= '0;
         bus.sr_latch    <= '0;
         bus.sr_byte_sel <= '0;
         bus.sr_len      <= '0;
         bus.sr_go       <= 1'b0;
         bus.ss_pad_o    <= '1;
      end else begin
         bus.ack <= '0;
         case (state)
            SEQ_IDLE: begin
               if (gap_cnt != GAP_MAX) begin
                  gap_cnt <= gap_cnt + GAP_W'(1);
               end
               if ((|bus.req) && (gap_cnt == GAP_MAX)) begin
                  idx_q           <= grant_idx;
                  gnt_q           <= grant;
                  bus.sr_latch    <= 4'b0001;
                  bus.sr_byte_sel <= 4'hF;
                  bus.sr_p_in     <= sel_data;
                  bus.sr_len      <= sel_len;
                  bus.ss_pad_o    <= ~sel_mask;
                  bus.busy        <= 1'b1;
                  state           <= SEQ_LOAD;
               end
            end
            SEQ_LOAD: begin
               bus.sr_latch    <= '0;
               bus.sr_byte_sel <= '0;
               bus.sr_go       <= 1'b1;
               state           <= SEQ_GO;
            end
            SEQ_GO: begin
               if (bus.sr_tip) begin
                  bus.sr_go <= 1'b0;
                  state     <= SEQ_BUSY;
               end
            end
            SEQ_BUSY: begin
               if (!bus.sr_tip) begin
                  bus.rdata    <= bus.sr_p_out;
                  bus.ack      <= gnt_q;
                  bus.ss_pad_o <= '1;
                  gap_cnt      <= '0;
                  rr_ptr       <= (idx_q == IDX_MAX) ? '0 : idx_q + IDX_W'(1);
                  state        <= SEQ_DONE;
               end
            end
            SEQ_DONE: begin
               if (gap_cnt != GAP_MAX) begin
                  gap_cnt <= gap_cnt + GAP_W'(1);
               end
               bus.busy <= 1'b0;
               state    <= SEQ_IDLE;
            end
            default: begin
               state <= SEQ_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// Self-checking bench for spi_xfer_sequencer: behavioural shift register, table-driven transfers,
// scoreboard of expected acks/RX words, and directed round-robin, drop, reset and short-gap sequences.
module tb_spi_xfer_sequencer;
   import spi_xfer_sequencer_pkg::*;

   localparam int GAP_A = 4;
   localparam int LB    = SPI_CHAR_LEN_BITS;

   typedef struct {
      int          idx;
      logic [6:0]  len;
      logic [31:0] data;
      logic [7:0]  mask;
      int          tip_len;
      logic [7:0]  exp_ss;
      logic [6:0]  exp_len;
   } vec_t;

   typedef struct {
      logic [1:0]  ack;
      logic [31:0] rdata;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   n_pass = 0;
   int   n_checks = 0;
   int   tip_len_a = 8;
   exp_t sb[$];
   exp_t mon_e;
   vec_t vecs[4];
   vec_t post_rst;

   always #5 clk = ~clk;

   spi_xfer_sequencer_if #(.NUM_REQ(2), .SS_NB(8)) bus_a ();
   spi_xfer_sequencer_if #(.NUM_REQ(2), .SS_NB(8)) bus_b ();

   spi_xfer_sequencer #(.NUM_REQ(2), .SS_NB(8), .GAP_CYCLES(GAP_A)) dut_a (
      .wb_clk_in (clk),
      .wb_rst    (rst),
      .bus       (bus_a)
   );

   spi_xfer_sequencer #(.NUM_REQ(2), .SS_NB(8), .GAP_CYCLES(1)) dut_b (
      .wb_clk_in (clk),
      .wb_rst    (rst),
      .bus       (bus_b)
   );

   function automatic logic [31:0] rx_of(input logic [31:0] d);
      return {d[15:0], d[31:16]} ^ 32'h3C3C_0F0F;
   endfunction

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) $display("[TB] FAIL %s: got %h, required %h", name, act, req);
      else n_pass++;
   endtask

   task automatic check_min(input string name, input int act, input int min);
      n_checks++;
      if (act < min) $display("[TB] FAIL %s: got %0d, required >= %0d", name, act, min);
      else n_pass++;
   endtask

   // Shift register stand-in for instance A: tip rises the cycle after go, lasts tip_len_a cycles.
   initial begin
      logic [31:0] cap;
      bus_a.sr_tip   = 1'b0;
      bus_a.sr_p_out = 32'hDEAD_BEEF;
      forever begin
         @(posedge clk);
         #1;
         if (!rst && bus_a.sr_go === 1'b1 && bus_a.sr_tip === 1'b0) begin
            cap          = bus_a.sr_p_in;
            bus_a.sr_tip = 1'b1;
            for (int k = 0; k < tip_len_a; k++) begin
               @(posedge clk or posedge rst);
               if (rst) break;
            end
            if (!rst) begin
               #1;
               bus_a.sr_p_out = rx_of(cap);
            end
            bus_a.sr_tip = 1'b0;
         end
      end
   end

   // Same stand-in for instance B with a fixed three-cycle transfer.
   initial begin
      logic [31:0] cap;
      bus_b.sr_tip   = 1'b0;
      bus_b.sr_p_out = 32'hDEAD_BEEF;
      forever begin
         @(posedge clk);
         #1;
         if (!rst && bus_b.sr_go === 1'b1 && bus_b.sr_tip === 1'b0) begin
            cap          = bus_b.sr_p_in;
            bus_b.sr_tip = 1'b1;
            for (int k = 0; k < 3; k++) begin
               @(posedge clk or posedge rst);
               if (rst) break;
            end
            if (!rst) begin
               #1;
               bus_b.sr_p_out = rx_of(cap);
            end
            bus_b.sr_tip = 1'b0;
         end
      end
   end

   // Every ack from instance A is matched against the oldest scoreboard entry.
   always @(negedge clk) begin
      if (!rst && bus_a.ack !== 2'b00) begin
         if (sb.size() == 0) begin
            n_checks++;
            $display("[TB] FAIL ack_unexpected: got ack %b, required no ack", bus_a.ack);
         end else begin
            mon_e = sb.pop_front();
            check_output("ack_onehot", 32'(bus_a.ack), 32'(mon_e.ack));
            check_output("rdata", bus_a.rdata, mon_e.rdata);
         end
      end
   end

   int   gap_run = 0;
   logic gap_open = 1'b0;
   logic gap_ss_ok = 1'b1;

   // Selects must stay released for at least GAP_A cycles between an ack and the next load.
   always @(negedge clk) begin
      if (rst) begin
         gap_open = 1'b0;
      end else if (bus_a.ack !== 2'b00) begin
         gap_open  = 1'b1;
         gap_run   = 1;
         gap_ss_ok = (bus_a.ss_pad_o === 8'hFF);
      end else if (gap_open) begin
         if (bus_a.sr_latch === 4'b0001) begin
            check_min("gap_cycles", gap_run, GAP_A);
            check_output("gap_ss_high", 32'(gap_ss_ok), 32'd1);
            gap_open = 1'b0;
         end else begin
            gap_run++;
            if (bus_a.ss_pad_o !== 8'hFF) gap_ss_ok = 1'b0;
         end
      end
   end

   task automatic apply_stimulus(input vec_t v);
      int   c;
      int   tip_low_cyc;
      logic seen_tip;
      logic ss_ok;
      logic len_ok;
      exp_t e;
      repeat (GAP_A + 2) @(negedge clk);
      tip_len_a = v.tip_len;
      bus_a.req = '0;
      bus_a.req[v.idx] = 1'b1;
      bus_a.req_len[v.idx*LB +: LB] = v.len;
      bus_a.req_data[v.idx*32 +: 32] = v.data;
      bus_a.req_ss[v.idx*8 +: 8] = v.mask;
      e.ack   = 2'(1 << v.idx);
      e.rdata = rx_of(v.data);
      sb.push_back(e);
      @(negedge clk);
      check_output("load_latch", 32'(bus_a.sr_latch), 32'h1);
      check_output("load_byte_sel", 32'(bus_a.sr_byte_sel), 32'hF);
      check_output("load_p_in", bus_a.sr_p_in, v.data);
      check_output("load_len", 32'(bus_a.sr_len), 32'(v.exp_len));
      check_output("load_ss", 32'(bus_a.ss_pad_o), 32'(v.exp_ss));
      check_output("load_busy", 32'(bus_a.busy), 32'd1);
      @(negedge clk);
      check_output("go_high", 32'(bus_a.sr_go), 32'd1);
      check_output("go_latch_clear", 32'(bus_a.sr_latch), 32'h0);
      c = 0;
      tip_low_cyc = -1;
      seen_tip = 1'b0;
      ss_ok = 1'b1;
      len_ok = 1'b1;
      while (bus_a.ack === 2'b00 && c < 400) begin
         if (bus_a.ss_pad_o !== v.exp_ss) ss_ok = 1'b0;
         if (bus_a.sr_len !== v.exp_len) len_ok = 1'b0;
         if (bus_a.sr_tip === 1'b1) seen_tip = 1'b1;
         else if (seen_tip && tip_low_cyc < 0) tip_low_cyc = c;
         @(negedge clk);
         c++;
      end
      if (c >= 400) begin
         n_checks++;
         $display("[TB] FAIL ack_timeout: got no ack in %0d cycles, required an ack", c);
      end else begin
         check_output("ack_after_tip", 32'(c - tip_low_cyc), 32'd1);
         check_output("ss_held", 32'(ss_ok), 32'd1);
         check_output("len_held", 32'(len_ok), 32'd1);
         check_output("busy_in_done", 32'(bus_a.busy), 32'd1);
      end
      bus_a.req[v.idx] = 1'b0;
      @(negedge clk);
      check_output("ack_one_cycle", 32'(bus_a.ack), 32'd0);
      check_output("idle_busy", 32'(bus_a.busy), 32'd0);
   endtask

   initial begin
      #3_000_000;
      $display("[TB] FAIL watchdog: got simulation still running, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int c;
      int acks;
      logic quiet;
      exp_t e;

      vecs[0] = '{0, 7'd8,  32'h0000_00A5, 8'h01, 8,   8'hFE, 7'd8};
      vecs[1] = '{1, 7'd16, 32'h1234_5678, 8'h80, 16,  8'h7F, 7'd16};
      vecs[2] = '{0, 7'd0,  32'hCAFE_F00D, 8'h0C, 128, 8'hF3, 7'd0};
      vecs[3] = '{1, 7'd32, 32'hFFFF_0001, 8'h00, 32,  8'hFF, 7'd32};
      post_rst = '{1, 7'd12, 32'h0BAD_CAFE, 8'h40, 10, 8'hBF, 7'd12};

      rst = 1'b1;
      bus_a.req = '0; bus_a.req_len = '0; bus_a.req_data = '0; bus_a.req_ss = '0;
      bus_b.req = '0; bus_b.req_len = '0; bus_b.req_data = '0; bus_b.req_ss = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_output("rst_ss", 32'(bus_a.ss_pad_o), 32'hFF);
      check_output("rst_busy", 32'(bus_a.busy), 32'd0);
      check_output("rst_ack", 32'(bus_a.ack), 32'd0);
      check_output("rst_rdata", bus_a.rdata, 32'd0);
      check_output("rst_go", 32'(bus_a.sr_go), 32'd0);
      check_output("rst_latch", 32'(bus_a.sr_latch), 32'd0);
      check_output("rst_byte_sel", 32'(bus_a.sr_byte_sel), 32'd0);
      check_output("rst_len", 32'(bus_a.sr_len), 32'd0);
      check_output("rst_p_in", bus_a.sr_p_in, 32'd0);

      for (int i = 0; i < 4; i++) apply_stimulus(vecs[i]);

      // Both requesters held: grants must alternate 0,1,0,1.
      repeat (GAP_A + 2) @(negedge clk);
      tip_len_a = 4;
      bus_a.req_len = {7'd8, 7'd8};
      bus_a.req_data = {32'h0000_2222, 32'h1111_0000};
      bus_a.req_ss = {8'h02, 8'h01};
      for (int i = 0; i < 4; i++) begin
         e.ack   = (i % 2 == 0) ? 2'b01 : 2'b10;
         e.rdata = (i % 2 == 0) ? rx_of(32'h1111_0000) : rx_of(32'h0000_2222);
         sb.push_back(e);
      end
      bus_a.req = 2'b11;
      acks = 0;
      c = 0;
      while (acks < 4 && c < 400) begin
         @(negedge clk);
         c++;
         if (bus_a.ack !== 2'b00) acks++;
      end
      bus_a.req = 2'b00;
      check_output("rr_ack_count", 32'(acks), 32'd4);

      // Requester 1 withdraws mid-transfer: ack still arrives, no regrant afterwards.
      repeat (GAP_A + 2) @(negedge clk);
      tip_len_a = 6;
      bus_a.req_data[63:32] = 32'h89AB_CDEF;
      e.ack = 2'b10;
      e.rdata = rx_of(32'h89AB_CDEF);
      sb.push_back(e);
      bus_a.req = 2'b10;
      c = 0;
      while (bus_a.sr_tip !== 1'b1 && c < 50) begin
         @(negedge clk);
         c++;
      end
      @(negedge clk);
      bus_a.req = 2'b00;
      c = 0;
      while (bus_a.ack === 2'b00 && c < 50) begin
         @(negedge clk);
         c++;
      end
      check_output("drop_ack", 32'(bus_a.ack), 32'h2);
      quiet = 1'b1;
      repeat (12) begin
         @(negedge clk);
         if (bus_a.busy !== 1'b0 || bus_a.sr_latch !== 4'h0) quiet = 1'b0;
      end
      check_output("drop_no_regrant", 32'(quiet), 32'd1);

      // Reset while the shift register is busy.
      tip_len_a = 20;
      bus_a.req_data[31:0] = 32'h7777_8888;
      bus_a.req_ss[7:0] = 8'h03;
      bus_a.req = 2'b01;
      c = 0;
      while (bus_a.sr_tip !== 1'b1 && c < 50) begin
         @(negedge clk);
         c++;
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_output("midrst_go", 32'(bus_a.sr_go), 32'd0);
      check_output("midrst_ss", 32'(bus_a.ss_pad_o), 32'hFF);
      check_output("midrst_busy", 32'(bus_a.busy), 32'd0);
      check_output("midrst_ack", 32'(bus_a.ack), 32'd0);
      sb.delete();
      bus_a.req = 2'b00;
      @(negedge clk);
      rst = 1'b0;
      apply_stimulus(post_rst);

      // Instance B, one-cycle gap: next load two cycles after the ack.
      @(negedge clk);
      bus_b.req_len[6:0] = 7'd8;
      bus_b.req_data[31:0] = 32'h5555_AAAA;
      bus_b.req_ss[7:0] = 8'h10;
      bus_b.req = 2'b01;
      @(negedge clk);
      check_output("b_load_ss", 32'(bus_b.ss_pad_o), 32'hEF);
      c = 0;
      while (bus_b.ack === 2'b00 && c < 50) begin
         @(negedge clk);
         c++;
      end
      check_output("b_ack1", 32'(bus_b.ack), 32'h1);
      check_output("b_rdata", bus_b.rdata, rx_of(32'h5555_AAAA));
      c = 0;
      while (bus_b.sr_latch !== 4'b0001 && c < 20) begin
         @(negedge clk);
         c++;
      end
      check_output("b_load_after_ack", 32'(c), 32'd2);
      c = 0;
      while (bus_b.ack === 2'b00 && c < 50) begin
         @(negedge clk);
         c++;
      end
      check_output("b_ack2", 32'(bus_b.ack), 32'h1);
      bus_b.req = 2'b00;

      repeat (4) @(negedge clk);
      check_output("sb_drain", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
